muldiv_ctrl: RTL

Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and sequences a fixed-latency busy window. It also produces the stall term that the hazard logic ORs into the global `stall` while a D-stage HI/LO-class instruction must wait.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if
// Groups the E-stage request, the D-stage hazard query and the HI/LO
// result signals exchanged between the pipeline and muldiv_ctrl.
//   start    : E-stage instruction is a HI/LO-class op, qualifies op
//   op       : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a, b     : forwarded rs / rt values from E
//   md_D     : D-stage instruction is a HI/LO-class instruction
//   busy     : multiply or divide in progress
//   stall_md : stall term for the hazard logic
//   hi, lo   : architectural HI/LO registers
// modport master: the pipeline side; modport slave: the controller side.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Multi-cycle multiply/divide controller beside the E-stage ALU. Owns the
// HI/LO registers, computes MULT/MULTU/DIV/DIVU results at acceptance and
// holds them for a fixed busy window before committing them to HI/LO.
// MTHI/MTLO write HI/LO directly with no busy window.
// Parameters:
//   MUL_LAT : busy cycles for MULT/MULTU (1..15)
//   DIV_LAT : busy cycles for DIV/DIVU (1..15)
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_if slave (start/op/a/b/md_D in, busy/stall_md/hi/lo out)
module muldiv_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  localparam logic [3:0] MUL_CNT = MUL_LAT[3:0];
  localparam logic [3:0] DIV_CNT = DIV_LAT[3:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_arith;
  logic        accept;
  logic        complete;

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] safe_d;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] q_out;
  logic [31:0] r_out;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;

  // Ops 0..3 all have op[2] clear; they are the ones that open a busy window.
  assign is_arith = bus.start && !bus.op[2];
  assign accept   = (state == IDLE) && is_arith;
  // cnt <= 1 rather than == 1 so a RUN state can never get stuck on cnt == 0.
  assign complete = (state == RUN) && (cnt <= 4'd1);

  // Two's-complement product of sign-extended operands: the low 64 bits are
  // the exact signed product.
  assign a_sx   = {{32{bus.a[31]}}, bus.a};
  assign b_sx   = {{32{bus.b[31]}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Signed divide runs on magnitudes and fixes signs afterwards. The
  // magnitude of 0x80000000 is 0x80000000 as an unsigned value, so the
  // 0x80000000 / -1 case naturally yields quotient 0x80000000, remainder 0.
  assign signed_div = (bus.op == 3'd2);
  assign div_zero   = (bus.b == 32'd0);
  assign mag_a      = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign mag_b      = bus.b[31] ? (32'd0 - bus.b) : bus.b;
  assign div_n      = signed_div ? mag_a : bus.a;
  assign div_d      = signed_div ? mag_b : bus.b;
  // The divider never sees zero; a zero divisor result is discarded below.
  assign safe_d     = div_zero ? 32'd1 : div_d;
  assign q_raw      = div_n / safe_d;
  assign r_raw      = div_n % safe_d;
  assign q_out      = (signed_div && (bus.a[31] ^ bus.b[31])) ? (32'd0 - q_raw) : q_raw;
  assign r_out      = (signed_div && bus.a[31]) ? (32'd0 - r_raw) : r_raw;

  // Result selection. Divide by zero captures the current HI/LO so that the
  // commit at the end of the window leaves them unchanged.
  always_comb begin
    calc_hi = hi_q;
    calc_lo = lo_q;
    case (bus.op)
      3'd0: begin
        calc_hi = prod_s[63:32];
        calc_lo = prod_s[31:0];
      end
      3'd1: begin
        calc_hi = prod_u[63:32];
        calc_lo = prod_u[31:0];
      end
      3'd2, 3'd3: begin
        if (!div_zero) begin
          calc_hi = r_out;
          calc_lo = q_out;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Any start seen in RUN is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter, result holding registers and HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            res_hi <= calc_hi;
            res_lo <= calc_lo;
            cnt    <= bus.op[1] ? DIV_CNT : MUL_CNT;
          end else if (bus.start && (bus.op == 3'd4)) begin
            hi_q <= bus.a;
          end else if (bus.start && (bus.op == 3'd5)) begin
            lo_q <= bus.a;
          end
        end
        RUN: begin
          if (complete) begin
            cnt  <= 4'd0;
            hi_q <= res_hi;
            lo_q <= res_lo;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. The acceptance cycle itself already stalls a dependent D-stage op.
  always_comb begin
    bus.busy     = (state == RUN);
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    bus.stall_md = bus.md_D && ((state == RUN) || is_arith);
  end

endmodule
